// File: rtl/csr_sequencer.sv
// -----------------------------------------------------------------------------
// csr_sequencer
//
// Purpose:
//   Runs the supervisor-level CSR micro-sequences for a small RISC-V core:
//     * Zicsr instructions (CSRRW/RS/RC and their immediate forms): one
//       read-modify-write step on the addressed CSR.
//     * Trap entry: writes sepc, scause and stval, updates sstatus
//       (SPIE <- SIE, SIE <- 0, SPP <- current privilege), then reads stvec
//       to produce the redirect PC.
//     * SRET: updates sstatus (SIE <- SPIE, SPIE <- 1, SPP <- 0), reports the
//       old SPP as the privilege to resume at, then reads sepc for the
//       redirect PC.
//   The CSR file itself lives outside.  It is addressed by o_csr_select and
//   returns i_csr_regout combinationally.  Each sequence step lasts exactly
//   one cycle.  A one-cycle DONE state reports the results.
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_req_valid          request handshake in; o_req_ready is high in IDLE
//   o_req_ready          
//   i_kind               00 CSR instr, 01 trap entry, 10 SRET, 11 reserved
//   i_op                 CSR funct3
//   i_csr_addr           CSR address
//   i_operand            rs1 value or zero-extended zimm
//   i_src_zero           rs1 field / zimm is zero
//   i_epc                trap PC
//   i_cause              trap cause
//   i_tval               trap value
//   i_priv               current privilege (1 = S, 0 = U)
//   o_csr_select         CSR file address
//   o_csr_data           CSR file write data
//   o_csr_load           CSR file write enable
//   i_csr_regout         CSR file read data
//   o_done               one-cycle completion pulse
//   o_rd_data            old CSR value from the last CSR instruction
//   o_illegal            the last request was rejected
//   o_redirect_valid     PC redirect, only during o_done
//   o_redirect_pc        redirect target
//   o_ret_priv           privilege to resume at after SRET
// -----------------------------------------------------------------------------
module csr_sequencer (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [1:0]  i_kind,
    input  logic [2:0]  i_op,
    input  logic [11:0] i_csr_addr,
    input  logic [31:0] i_operand,
    input  logic        i_src_zero,
    input  logic [31:0] i_epc,
    input  logic [31:0] i_cause,
    input  logic [31:0] i_tval,
    input  logic        i_priv,
    output logic [11:0] o_csr_select,
    output logic [31:0] o_csr_data,
    output logic        o_csr_load,
    input  logic [31:0] i_csr_regout,
    output logic        o_done,
    output logic [31:0] o_rd_data,
    output logic        o_illegal,
    output logic        o_redirect_valid,
    output logic [31:0] o_redirect_pc,
    output logic        o_ret_priv
);

    localparam logic [1:0]  KIND_CSR  = 2'b00;
    localparam logic [1:0]  KIND_TRAP = 2'b01;
    localparam logic [1:0]  KIND_SRET = 2'b10;

    localparam logic [11:0] ADDR_SSTATUS = 12'h100;
    localparam logic [11:0] ADDR_STVEC   = 12'h105;
    localparam logic [11:0] ADDR_SEPC    = 12'h141;
    localparam logic [11:0] ADDR_SCAUSE  = 12'h142;
    localparam logic [11:0] ADDR_STVAL   = 12'h143;

    // Low two funct3 bits select the operation.  Bit 2 only marks the
    // immediate form, and the operand is already zero-extended for it.
    localparam logic [1:0]  OP_RW = 2'b01;
    localparam logic [1:0]  OP_RS = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CSR,
        ST_T_EPC,
        ST_T_CAUSE,
        ST_T_TVAL,
        ST_T_STATUS,
        ST_T_VEC,
        ST_R_STATUS,
        ST_R_EPC,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    // Request fields latched on accept
    logic [1:0]  op_q, op_d;
    logic [11:0] addr_q, addr_d;
    logic [31:0] operand_q, operand_d;
    logic        src_zero_q, src_zero_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] tval_q, tval_d;
    logic        priv_q, priv_d;

    // Result registers.  They change only on the edge that enters DONE, so
    // they hold from one completion to the next.
    logic [31:0] rd_data_q, rd_data_d;
    logic        illegal_q, illegal_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        ret_priv_q, ret_priv_d;
    logic        redirect_flag_q, redirect_flag_d;
    // Old SPP is seen in R_STATUS one cycle before DONE.  It is parked
    // here so that o_ret_priv does not change ahead of the completion.
    logic        ret_priv_pend_q, ret_priv_pend_d;

    logic        accept;
    logic        op_legal;
    logic        step_load;

    assign accept   = i_req_valid && o_req_ready;
    // funct3 000 and 100 have no CSR operation
    assign op_legal = (i_op[1:0] != 2'b00);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (i_kind)
                        KIND_CSR:  state_d = op_legal ? ST_CSR : ST_DONE;
                        KIND_TRAP: state_d = ST_T_EPC;
                        KIND_SRET: state_d = ST_R_STATUS;
                        default:   state_d = ST_DONE;
                    endcase
                end
            end
            ST_CSR:      state_d = ST_DONE;
            ST_T_EPC:    state_d = ST_T_CAUSE;
            ST_T_CAUSE:  state_d = ST_T_TVAL;
            ST_T_TVAL:   state_d = ST_T_STATUS;
            ST_T_STATUS: state_d = ST_T_VEC;
            ST_T_VEC:    state_d = ST_DONE;
            ST_R_STATUS: state_d = ST_R_EPC;
            ST_R_EPC:    state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        o_req_ready      = (state_q == ST_IDLE) && !i_rst;
        o_done           = (state_q == ST_DONE) && !i_rst;
        o_redirect_valid = (state_q == ST_DONE) && !i_rst && redirect_flag_q;

        o_csr_select = 12'h000;
        o_csr_data   = 32'h0000_0000;
        step_load    = 1'b0;

        case (state_q)
            ST_CSR: begin
                o_csr_select = addr_q;
                case (op_q)
                    OP_RW:   o_csr_data = operand_q;
                    OP_RS:   o_csr_data = i_csr_regout | operand_q;
                    default: o_csr_data = i_csr_regout & ~operand_q;
                endcase
                // Set/clear with a zero source is a pure read
                step_load = !(op_q != OP_RW && src_zero_q);
            end
            ST_T_EPC: begin
                o_csr_select = ADDR_SEPC;
                o_csr_data   = epc_q;
                step_load    = 1'b1;
            end
            ST_T_CAUSE: begin
                o_csr_select = ADDR_SCAUSE;
                o_csr_data   = cause_q;
                step_load    = 1'b1;
            end
            ST_T_TVAL: begin
                o_csr_select = ADDR_STVAL;
                o_csr_data   = tval_q;
                step_load    = 1'b1;
            end
            ST_T_STATUS: begin
                o_csr_select  = ADDR_SSTATUS;
                o_csr_data    = i_csr_regout;
                o_csr_data[5] = i_csr_regout[1];   // SPIE <- SIE
                o_csr_data[1] = 1'b0;              // SIE  <- 0
                o_csr_data[8] = priv_q;            // SPP  <- privilege
                step_load     = 1'b1;
            end
            ST_T_VEC: begin
                o_csr_select = ADDR_STVEC;
            end
            ST_R_STATUS: begin
                o_csr_select  = ADDR_SSTATUS;
                o_csr_data    = i_csr_regout;
                o_csr_data[1] = i_csr_regout[5];   // SIE  <- SPIE
                o_csr_data[5] = 1'b1;              // SPIE <- 1
                o_csr_data[8] = 1'b0;              // SPP  <- U
                step_load     = 1'b1;
            end
            ST_R_EPC: begin
                o_csr_select = ADDR_SEPC;
            end
            default: begin
            end
        endcase

        // Reset kills a write in the same cycle, so an aborted sequence
        // leaves no partial update.
        o_csr_load    = step_load && !i_rst;

        o_rd_data     = rd_data_q;
        o_illegal     = illegal_q;
        o_redirect_pc = redirect_pc_q;
        o_ret_priv    = ret_priv_q;
    end

    // ------------------------------------------------------------------
    // Request latch and result capture
    // ------------------------------------------------------------------
    always_comb begin
        op_d            = op_q;
        addr_d          = addr_q;
        operand_d       = operand_q;
        src_zero_d      = src_zero_q;
        epc_d           = epc_q;
        cause_d         = cause_q;
        tval_d          = tval_q;
        priv_d          = priv_q;
        rd_data_d       = rd_data_q;
        illegal_d       = illegal_q;
        redirect_pc_d   = redirect_pc_q;
        ret_priv_d      = ret_priv_q;
        redirect_flag_d = redirect_flag_q;
        ret_priv_pend_d = ret_priv_pend_q;

        if (accept) begin
            op_d       = i_op[1:0];
            addr_d     = i_csr_addr;
            operand_d  = i_operand;
            src_zero_d = i_src_zero;
            epc_d      = i_epc;
            cause_d    = i_cause;
            tval_d     = i_tval;
            priv_d     = i_priv;
        end

        case (state_q)
            ST_IDLE: begin
                // The only direct IDLE -> DONE routes are rejections
                if (accept && state_d == ST_DONE) begin
                    illegal_d       = 1'b1;
                    rd_data_d       = 32'h0000_0000;
                    redirect_flag_d = 1'b0;
                end
            end
            ST_CSR: begin
                rd_data_d       = i_csr_regout;
                illegal_d       = 1'b0;
                redirect_flag_d = 1'b0;
            end
            ST_T_VEC: begin
                redirect_pc_d   = {i_csr_regout[31:2], 2'b00};
                illegal_d       = 1'b0;
                redirect_flag_d = 1'b1;
            end
            ST_R_STATUS: begin
                ret_priv_pend_d = i_csr_regout[8];
            end
            ST_R_EPC: begin
                redirect_pc_d   = i_csr_regout;
                ret_priv_d      = ret_priv_pend_q;
                illegal_d       = 1'b0;
                redirect_flag_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            op_q            <= 2'b00;
            addr_q          <= 12'h000;
            operand_q       <= 32'h0000_0000;
            src_zero_q      <= 1'b0;
            epc_q           <= 32'h0000_0000;
            cause_q         <= 32'h0000_0000;
            tval_q          <= 32'h0000_0000;
            priv_q          <= 1'b0;
            rd_data_q       <= 32'h0000_0000;
            illegal_q       <= 1'b0;
            redirect_pc_q   <= 32'h0000_0000;
            ret_priv_q      <= 1'b0;
            redirect_flag_q <= 1'b0;
            ret_priv_pend_q <= 1'b0;
        end else begin
            op_q            <= op_d;
            addr_q          <= addr_d;
            operand_q       <= operand_d;
            src_zero_q      <= src_zero_d;
            epc_q           <= epc_d;
            cause_q         <= cause_d;
            tval_q          <= tval_d;
            priv_q          <= priv_d;
            rd_data_q       <= rd_data_d;
            illegal_q       <= illegal_d;
            redirect_pc_q   <= redirect_pc_d;
            ret_priv_q      <= ret_priv_d;
            redirect_flag_q <= redirect_flag_d;
            ret_priv_pend_q <= ret_priv_pend_d;
        end
    end

endmodule

// File: tb/tb_csr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_csr_sequencer
//
// Scoreboard bench for csr_sequencer.  A CSR array stands in for the CSR
// file.  The issuing process computes each request's effect from the
// architectural rules against a shadow copy of the CSRs.  It queues the
// expected writes and the expected completion.  A monitor running on the
// falling edge pops and compares whenever the DUT writes or completes.
// -----------------------------------------------------------------------------
module tb_csr_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic [1:0]  i_kind = 2'b00;
    logic [2:0]  i_op = 3'b000;
    logic [11:0] i_csr_addr = 12'h000;
    logic [31:0] i_operand = 32'h0;
    logic        i_src_zero = 1'b0;
    logic [31:0] i_epc = 32'h0;
    logic [31:0] i_cause = 32'h0;
    logic [31:0] i_tval = 32'h0;
    logic        i_priv = 1'b0;
    logic [11:0] o_csr_select;
    logic [31:0] o_csr_data;
    logic        o_csr_load;
    logic [31:0] i_csr_regout;
    logic        o_done;
    logic [31:0] o_rd_data;
    logic        o_illegal;
    logic        o_redirect_valid;
    logic [31:0] o_redirect_pc;
    logic        o_ret_priv;

    always #5 i_clk = ~i_clk;

    csr_sequencer dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_req_valid      (i_req_valid),
        .o_req_ready      (o_req_ready),
        .i_kind           (i_kind),
        .i_op             (i_op),
        .i_csr_addr       (i_csr_addr),
        .i_operand        (i_operand),
        .i_src_zero       (i_src_zero),
        .i_epc            (i_epc),
        .i_cause          (i_cause),
        .i_tval           (i_tval),
        .i_priv           (i_priv),
        .o_csr_select     (o_csr_select),
        .o_csr_data       (o_csr_data),
        .o_csr_load       (o_csr_load),
        .i_csr_regout     (i_csr_regout),
        .o_done           (o_done),
        .o_rd_data        (o_rd_data),
        .o_illegal        (o_illegal),
        .o_redirect_valid (o_redirect_valid),
        .o_redirect_pc    (o_redirect_pc),
        .o_ret_priv       (o_ret_priv)
    );

    // ---------------- CSR file stand-in ----------------
    bit   [31:0] csr_mem [4096];
    bit   [31:0] ref_csr [4096];
    logic        pre_en = 1'b0;
    logic [11:0] pre_addr = 12'h0;
    logic [31:0] pre_data = 32'h0;

    assign i_csr_regout = csr_mem[o_csr_select];

    always @(posedge i_clk) begin
        if (pre_en)
            csr_mem[pre_addr] <= pre_data;
        else if (o_csr_load)
            csr_mem[o_csr_select] <= o_csr_data;
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic        ill;
        logic [31:0] rd;
        logic        rv;
        logic [31:0] rpc;
        logic        rp;
        logic [7:0]  lat;
    } done_t;

    wr_t   wr_q[$];
    done_t exp_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int done_cnt = 0;

    // Model's view of the held result registers
    logic [31:0] m_rd = 32'h0;
    logic [31:0] m_rpc = 32'h0;
    logic        m_rp = 1'b0;
    logic        m_ill = 1'b0;

    // Held values last confirmed at a completion, used between completions
    logic [31:0] last_rd = 32'h0;
    logic [31:0] last_rpc = 32'h0;
    logic        last_rp = 1'b0;
    logic        last_ill = 1'b0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge
    always @(negedge i_clk) begin
        wr_t   w;
        done_t e;
        if (i_rst) begin
            chk("rst_load", {31'b0, o_csr_load}, 32'h0);
            chk("rst_done", {31'b0, o_done}, 32'h0);
            chk("rst_redirect_valid", {31'b0, o_redirect_valid}, 32'h0);
            chk("rst_ready", {31'b0, o_req_ready}, 32'h0);
            last_rd  = 32'h0;
            last_rpc = 32'h0;
            last_rp  = 1'b0;
            last_ill = 1'b0;
        end else begin
            if (o_csr_load) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", {20'h0, o_csr_select}, 32'hFFFF_FFFF);
                end else begin
                    w = wr_q.pop_front();
                    chk("write_addr", {20'h0, o_csr_select}, {20'h0, w.addr});
                    chk("write_data", o_csr_data, w.data);
                    $display("write csr=%03h data=%08h", o_csr_select, o_csr_data);
                end
            end
            if (o_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'h1, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("illegal", {31'b0, o_illegal}, {31'b0, e.ill});
                    chk("rd_data", o_rd_data, e.rd);
                    chk("redirect_valid", {31'b0, o_redirect_valid}, {31'b0, e.rv});
                    chk("redirect_pc", o_redirect_pc, e.rpc);
                    chk("ret_priv", {31'b0, o_ret_priv}, {31'b0, e.rp});
                    chk("latency", 32'(cyc - acc_cyc), {24'h0, e.lat});
                    chk("writes_before_done", 32'(wr_q.size()), 32'h0);
                    last_rd  = e.rd;
                    last_rpc = e.rpc;
                    last_rp  = e.rp;
                    last_ill = e.ill;
                    $display("done ill=%0d rd=%08h rv=%0d rpc=%08h rp=%0d lat=%0d",
                             o_illegal, o_rd_data, o_redirect_valid, o_redirect_pc,
                             o_ret_priv, cyc - acc_cyc);
                end
                done_cnt++;
            end else begin
                chk("hold_rd_data", o_rd_data, last_rd);
                chk("hold_redirect_pc", o_redirect_pc, last_rpc);
                chk("hold_illegal", {31'b0, o_illegal}, {31'b0, last_ill});
                chk("hold_ret_priv", {31'b0, o_ret_priv}, {31'b0, last_rp});
                chk("idle_redirect_valid", {31'b0, o_redirect_valid}, 32'h0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_csr(input logic [11:0] a, input logic [31:0] v);
        @(posedge i_clk);
        #1;
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = v;
        ref_csr[a] = v;
        @(posedge i_clk);
        #1;
        pre_en = 1'b0;
    endtask

    task automatic scramble();
        i_kind     = 2'($urandom);
        i_op       = 3'($urandom);
        i_csr_addr = 12'($urandom);
        i_operand  = $urandom;
        i_src_zero = 1'($urandom);
        i_epc      = $urandom;
        i_cause    = $urandom;
        i_tval     = $urandom;
        i_priv     = 1'($urandom);
    endtask

    // Issue one request.  With abort_rst set the request must be a trap
    // and reset is raised while it is writing scause.
    task automatic issue(input logic [1:0] kind, input logic [2:0] op,
                         input logic [11:0] addr, input logic [31:0] opnd,
                         input logic sz, input logic [31:0] epc,
                         input logic [31:0] cause, input logic [31:0] tval,
                         input logic priv, input bit abort_rst);
        done_t       e;
        wr_t         w;
        logic [31:0] old;
        logic [31:0] nv;
        int          n;
        int          start;

        // Reference model
        e.rd  = m_rd;
        e.rpc = m_rpc;
        e.rp  = m_rp;
        e.ill = 1'b0;
        e.rv  = 1'b0;
        e.lat = 8'd1;
        if (abort_rst) begin
            // Only sepc gets written before reset arrives
            w.addr = 12'h141; w.data = epc; wr_q.push_back(w);
            ref_csr[12'h141] = epc;
        end else begin
            case (kind)
                2'b00: begin
                    if (op == 3'b000 || op == 3'b100) begin
                        e.ill = 1'b1;
                        e.rd  = 32'h0;
                        e.lat = 8'd1;
                    end else begin
                        old  = ref_csr[addr];
                        e.rd = old;
                        if (op == 3'b001 || op == 3'b101)
                            nv = opnd;
                        else if (op == 3'b010 || op == 3'b110)
                            nv = old | opnd;
                        else
                            nv = old & ~opnd;
                        if (op == 3'b001 || op == 3'b101 || !sz) begin
                            w.addr = addr; w.data = nv; wr_q.push_back(w);
                            ref_csr[addr] = nv;
                        end
                        e.lat = 8'd2;
                    end
                end
                2'b01: begin
                    w.addr = 12'h141; w.data = epc;   wr_q.push_back(w);
                    w.addr = 12'h142; w.data = cause; wr_q.push_back(w);
                    w.addr = 12'h143; w.data = tval;  wr_q.push_back(w);
                    ref_csr[12'h141] = epc;
                    ref_csr[12'h142] = cause;
                    ref_csr[12'h143] = tval;
                    old = ref_csr[12'h100];
                    nv  = (old & ~32'h0000_0122) | (32'(old[1]) << 5) | (32'(priv) << 8);
                    w.addr = 12'h100; w.data = nv; wr_q.push_back(w);
                    ref_csr[12'h100] = nv;
                    e.rpc = ref_csr[12'h105] & ~32'h3;
                    e.rv  = 1'b1;
                    e.lat = 8'd6;
                end
                2'b10: begin
                    old  = ref_csr[12'h100];
                    nv   = (old & ~32'h0000_0122) | (32'(old[5]) << 1) | 32'h20;
                    w.addr = 12'h100; w.data = nv; wr_q.push_back(w);
                    ref_csr[12'h100] = nv;
                    e.rp  = old[8];
                    e.rpc = ref_csr[12'h141];
                    e.rv  = 1'b1;
                    e.lat = 8'd3;
                end
                default: begin
                    e.ill = 1'b1;
                    e.rd  = 32'h0;
                    e.lat = 8'd1;
                end
            endcase
            m_rd  = e.rd;
            m_rpc = e.rpc;
            m_rp  = e.rp;
            m_ill = e.ill;
            exp_q.push_back(e);
        end

        // Drive and wait for accept
        @(posedge i_clk);
        #1;
        i_kind = kind; i_op = op; i_csr_addr = addr; i_operand = opnd;
        i_src_zero = sz; i_epc = epc; i_cause = cause; i_tval = tval;
        i_priv = priv; i_req_valid = 1'b1;
        start = done_cnt;
        n = 0;
        @(negedge i_clk);
        while (!o_req_ready && n < 30) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_req_ready) begin
            chk("accept_timeout", 32'h0, 32'h1);
            i_req_valid = 1'b0;
            return;
        end
        acc_cyc = cyc;
        $display("req kind=%0d op=%0d addr=%03h opnd=%08h sz=%0d priv=%0d abort=%0d",
                 kind, op, addr, opnd, sz, priv, abort_rst);

        // Busy: present garbage with valid high for one cycle; it must be ignored
        @(posedge i_clk);
        #1;
        scramble();
        i_req_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_req_valid = 1'b0;
        scramble();

        if (abort_rst) begin
            i_rst = 1'b1;
            @(posedge i_clk);
            #1;
            i_rst = 1'b0;
            m_rd = 32'h0; m_rpc = 32'h0; m_rp = 1'b0; m_ill = 1'b0;
            @(negedge i_clk);
            chk("ready_after_reset", {31'b0, o_req_ready}, 32'h1);
            chk("abort_pending_writes", 32'(wr_q.size()), 32'h0);
        end else begin
            n = 0;
            while (done_cnt == start && n < 20) begin
                @(negedge i_clk);
                n++;
            end
            if (done_cnt == start)
                chk("done_timeout", 32'h0, 32'h1);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [1:0]  kind;
        logic [2:0]  op;
        logic [11:0] addr;
        logic [31:0] opnd;
        int          r;

        i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        set_csr(12'h100, 32'h0000_0020);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("reset_ready", {31'b0, o_req_ready}, 32'h1);
        chk("reset_rd_data", o_rd_data, 32'h0);
        chk("reset_redirect_pc", o_redirect_pc, 32'h0);

        // CSRRS sstatus |= 0x2, old 0x20
        issue(2'b00, 3'b010, 12'h100, 32'h2, 1'b0, 0, 0, 0, 1'b0, 0);
        // CSRRC with zero source, old 0xFF
        set_csr(12'h180, 32'h0000_00FF);
        issue(2'b00, 3'b011, 12'h180, 32'h0, 1'b1, 0, 0, 0, 1'b0, 0);
        // Trap entry
        set_csr(12'h100, 32'h0000_0002);
        set_csr(12'h105, 32'h8000_0103);
        issue(2'b01, 3'b000, 12'h000, 32'h0, 1'b0, 32'h8000_1000, 32'h8, 32'h0, 1'b0, 0);
        // SRET
        set_csr(12'h100, 32'h0000_0120);
        set_csr(12'h141, 32'h0000_1234);
        issue(2'b10, 3'b000, 12'h000, 32'h0, 1'b0, 0, 0, 0, 1'b0, 0);
        // Illegal funct3 and reserved kind
        issue(2'b00, 3'b100, 12'h100, 32'h5, 1'b0, 0, 0, 0, 1'b0, 0);
        issue(2'b11, 3'b001, 12'h100, 32'h5, 1'b0, 0, 0, 0, 1'b0, 0);
        // Reset during the scause write
        issue(2'b01, 3'b000, 12'h000, 32'h0, 1'b0, 32'hDEAD_0000, 32'h5, 32'h77, 1'b1, 1);

        // Randomized mix
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            kind = (r < 5) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            op   = 3'($urandom);
            case ($urandom_range(0, 6))
                0: addr = 12'h100;
                1: addr = 12'h105;
                2: addr = 12'h141;
                3: addr = 12'h142;
                4: addr = 12'h143;
                5: addr = 12'h180;
                default: addr = 12'($urandom);
            endcase
            if (op[2])
                opnd = 32'($urandom_range(0, 31));
            else
                opnd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 4) == 0)
                set_csr(12'h100, $urandom);
            issue(kind, op, addr, opnd, (opnd == 32'h0), $urandom, $urandom,
                  $urandom, 1'($urandom), 0);
        end

        repeat (4) @(negedge i_clk);
        chk("final_wr_queue", 32'(wr_q.size()), 32'h0);
        chk("final_exp_queue", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
